// File: rtl/ap_rst_seq_mc.sv
// Multi-channel kernel reset/start sequencer: staggered per-channel auto-reset, one common
// start pulse, done aggregation into a single ap_done, optional output register pipeline.
module ap_rst_seq_mc #(
   parameter int NUM_CH     = 4,
   parameter int RST_CYCLES = 20,
   parameter int STAGGER    = 4,
   parameter int START_DLY  = 20,
   parameter int OUT_PIPE   = 6
) (
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              ap_start,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic [NUM_CH-1:0] ch_done,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic [NUM_CH-1:0] ch_start,
   output logic              ap_done,
   output logic              ap_idle
);

   localparam int LAST_REL = RST_CYCLES + (NUM_CH - 1) * STAGGER;
   localparam int START_AT = LAST_REL + START_DLY;
   localparam int CNT_W    = $clog2(START_AT + 1);
   localparam int PW       = 2 * NUM_CH + 2;

   localparam logic [CNT_W-1:0] CNT_RST_END = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_REL_END = CNT_W'(LAST_REL - 1);
   localparam logic [CNT_W-1:0] CNT_START   = CNT_W'(START_AT);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RESET   = 3'd1;
   localparam logic [2:0] S_RELEASE = 3'd2;
   localparam logic [2:0] S_WAIT    = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;

   logic [1:0]        sync_reg;
   logic              rst_int;
   logic [2:0]        state_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [NUM_CH-1:0] mask_q_reg;
   logic [NUM_CH-1:0] done_seen_reg;
   logic              ap_start_q;
   logic              ap_done_reg;
   logic              trigger;
   logic              all_done;
   logic              in_reset;
   logic [NUM_CH-1:0] hold;
   logic [NUM_CH-1:0] rst_n_int;
   logic [NUM_CH-1:0] start_int;
   logic              idle_int;
   logic [PW-1:0]     out_int;
   logic [PW-1:0]     out_vec;

   // Reset asserts immediately, releases two clock edges after ap_rst falls.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) sync_reg <= 2'b11;
      else        sync_reg <= {sync_reg[0], 1'b0};
   end
   assign rst_int = sync_reg[1];

   assign trigger  = ap_start & ~ap_start_q;
   assign all_done = ((done_seen_reg | ch_done) & mask_q_reg) == mask_q_reg;
   assign in_reset = (state_reg == S_RESET) || (state_reg == S_RELEASE);

   always_ff @(posedge ap_clk or posedge rst_int) begin
      if (rst_int) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         mask_q_reg    <= '0;
         done_seen_reg <= '0;
         ap_start_q    <= 1'b1;
         ap_done_reg   <= 1'b0;
      end else begin
         ap_start_q  <= ap_start;
         ap_done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (trigger) begin
                  mask_q_reg    <= ch_mask;
                  cnt_reg       <= '0;
                  done_seen_reg <= '0;
                  // An empty mask passes through RUN for one cycle, which completes at once.
                  state_reg     <= (ch_mask == '0) ? S_RUN : S_RESET;
               end
            end
            S_RESET: begin
               cnt_reg <= cnt_reg + CNT_ONE;
               if (cnt_reg == CNT_RST_END)
                  state_reg <= (cnt_reg == CNT_REL_END) ? S_WAIT : S_RELEASE;
            end
            S_RELEASE: begin
               cnt_reg <= cnt_reg + CNT_ONE;
               if (cnt_reg == CNT_REL_END) state_reg <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_reg == CNT_START) state_reg <= S_RUN;
               else                      cnt_reg   <= cnt_reg + CNT_ONE;
            end
            S_RUN: begin
               if (all_done) begin
                  ap_done_reg   <= 1'b1;
                  done_seen_reg <= '0;
                  state_reg     <= S_IDLE;
               end else begin
                  done_seen_reg <= done_seen_reg | (ch_done & mask_q_reg);
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Channel k is held for RST_CYCLES + k*STAGGER cycles counted from the trigger edge.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         localparam logic [CNT_W-1:0] THR = CNT_W'(RST_CYCLES + gi * STAGGER);
         assign hold[gi] = in_reset & mask_q_reg[gi] & (cnt_reg < THR);
      end
   endgenerate

   assign rst_n_int = rst_int ? '0 : ~hold;
   assign start_int = (!rst_int && state_reg == S_WAIT && cnt_reg == CNT_START) ? mask_q_reg : '0;
   assign idle_int  = !rst_int && (state_reg == S_IDLE);
   assign out_int   = {rst_n_int, start_int, ap_done_reg, idle_int};

   generate
      if (OUT_PIPE == 0) begin : g_nopipe
         assign out_vec = out_int;
      end else begin : g_pipe
         logic [PW-1:0] pipe_reg [OUT_PIPE];
         always_ff @(posedge ap_clk or posedge rst_int) begin
            if (rst_int) begin
               for (int i = 0; i < OUT_PIPE; i++) pipe_reg[i] <= '0;
            end else begin
               pipe_reg[0] <= out_int;
               for (int i = 1; i < OUT_PIPE; i++) pipe_reg[i] <= pipe_reg[i-1];
            end
         end
         assign out_vec = pipe_reg[OUT_PIPE-1];
      end
   endgenerate

   assign {ch_rst_n, ch_start, ap_done, ap_idle} = out_vec;

endmodule

// File: tb/tb_ap_rst_seq_mc.sv
// Bench for ap_rst_seq_mc: reset sequences, table-driven runs and random runs checked
// cycle by cycle against an interval/set-based reference model.
module tb_ap_rst_seq_mc;

   localparam int NUM_CH     = 4;
   localparam int RST_CYCLES = 20;
   localparam int STAGGER    = 4;
   localparam int START_DLY  = 20;
   localparam int OUT_PIPE   = 6;
   localparam int ST         = RST_CYCLES + (NUM_CH - 1) * STAGGER + START_DLY;
   localparam int LEN        = 256;
   localparam logic [9:0] OUT_RST  = 10'b0;
   localparam logic [9:0] OUT_IDLE = {4'hF, 4'h0, 1'b0, 1'b1};

   logic       ap_clk = 1'b0;
   logic       ap_rst = 1'b0;
   logic       ap_start = 1'b0;
   logic [3:0] ch_mask = 4'h0;
   logic [3:0] ch_done = 4'h0;
   logic [3:0] ch_rst_n;
   logic [3:0] ch_start;
   logic       ap_done;
   logic       ap_idle;

   int total = 0;
   int bad   = 0;

   logic [3:0] dstream   [LEN];
   logic [3:0] exp_rstn  [LEN];
   logic [3:0] exp_start [LEN];
   logic       exp_done  [LEN];
   logic       exp_idle  [LEN];
   int         cdone;

   typedef struct {
      logic [3:0]      mask;
      logic [3:0][7:0] da;
      logic [3:0][7:0] db;
      int              exp_done;
   } vec_t;
   vec_t tab [8];

   ap_rst_seq_mc #(
      .NUM_CH(NUM_CH), .RST_CYCLES(RST_CYCLES), .STAGGER(STAGGER),
      .START_DLY(START_DLY), .OUT_PIPE(OUT_PIPE)
   ) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ch_mask(ch_mask),
      .ch_done(ch_done), .ch_rst_n(ch_rst_n), .ch_start(ch_start),
      .ap_done(ap_done), .ap_idle(ap_idle)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input int c, input logic [9:0] act, input logic [9:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s cycle %0d: got rst_n=%h start=%h done=%b idle=%b, want rst_n=%h start=%h done=%b idle=%b",
                  name, c, act[9:6], act[5:2], act[1], act[0], expv[9:6], expv[5:2], expv[1], expv[0]);
      end
   endtask

   task automatic check_int(input string name, input int act, input int expv);
      total++;
      if (act != expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, expv);
      end
   endtask

   // Expected outputs from the rules: reset windows, start time, first cycle all masked dones seen.
   function automatic void build_model(input logic [3:0] m);
      logic [3:0] seen;
      seen  = '0;
      cdone = LEN - OUT_PIPE - 5;
      if (m == 4'h0) cdone = 0;
      else begin
         for (int c = ST + 1; c < LEN - OUT_PIPE - 5; c++) begin
            seen = seen | (dstream[c] & m);
            if (seen == m) begin
               cdone = c;
               break;
            end
         end
      end
      for (int t = 0; t < LEN; t++) begin
         int c;
         c = t - OUT_PIPE;
         exp_rstn[t]  = 4'hF;
         exp_start[t] = 4'h0;
         exp_done[t]  = (c == cdone + 1);
         exp_idle[t]  = !(c >= 0 && c <= cdone);
         if (c >= 0 && c <= cdone)
            for (int k = 0; k < 4; k++)
               if (m[k] && c < RST_CYCLES + k * STAGGER) exp_rstn[t][k] = 1'b0;
         if (m != 4'h0 && c == ST) exp_start[t] = m;
      end
   endfunction

   task automatic run_scn(input string name, input logic [3:0] m, input bit hold, input bit toggle,
                          output int done_at);
      build_model(m);
      done_at = -1;
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      ch_done  = 4'h0;
      @(posedge ap_clk); #1;
      ap_start = 1'b1;
      ch_mask  = m;
      for (int c = 0; c <= cdone + OUT_PIPE + 3; c++) begin
         @(posedge ap_clk); #1;
         ch_done = dstream[c];
         ch_mask = 4'($urandom_range(0, 15));
         if (c < cdone) ap_start = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         else           ap_start = hold;
         @(negedge ap_clk);
         if (ap_done === 1'b1 && done_at < 0) done_at = c;
         check(name, c, {ch_rst_n, ch_start, ap_done, ap_idle},
               {exp_rstn[c], exp_start[c], exp_done[c], exp_idle[c]});
      end
      ap_start = 1'b0;
      ch_done  = 4'h0;
   endtask

   // Release ap_rst and watch: reset values for 2 sync + 6 pipe cycles, then steady idle.
   task automatic release_watch(input string name, input int n);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      for (int k = 0; k <= n; k++) begin
         if (k > 0) @(posedge ap_clk);
         @(negedge ap_clk);
         check(name, k, {ch_rst_n, ch_start, ap_done, ap_idle}, (k < 8) ? OUT_RST : OUT_IDLE);
      end
   endtask

   task automatic clear_stream();
      for (int c = 0; c < LEN; c++) dstream[c] = 4'h0;
   endtask

   initial begin
      int done_at;
      tab[0] = '{4'hF, {8'd70, 8'd70, 8'd70, 8'd70}, {4{8'hFF}}, 77};
      tab[1] = '{4'h5, {8'hFF, 8'd80, 8'd60, 8'd70}, {4{8'hFF}}, 87};
      tab[2] = '{4'h0, {4{8'hFF}}, {4{8'hFF}}, 7};
      tab[3] = '{4'h8, {8'd52, 8'hFF, 8'hFF, 8'hFF}, {8'd53, 8'hFF, 8'hFF, 8'hFF}, 60};
      tab[4] = '{4'hF, {8'd53, 8'd53, 8'd53, 8'd53}, {4{8'hFF}}, 60};
      tab[5] = '{4'h3, {8'hFF, 8'hFF, 8'd60, 8'd40}, {8'hFF, 8'hFF, 8'hFF, 8'd120}, 127};
      tab[6] = '{4'h2, {8'hFF, 8'hFF, 8'd55, 8'd54}, {4{8'hFF}}, 62};
      tab[7] = '{4'hF, {8'd56, 8'd55, 8'd54, 8'd53}, {4{8'hFF}}, 63};

      // Power-up reset, then 200 quiet idle cycles.
      #2 ap_rst = 1'b1;
      repeat (3) @(posedge ap_clk);
      @(negedge ap_clk);
      check("por_hold", 0, {ch_rst_n, ch_start, ap_done, ap_idle}, OUT_RST);
      release_watch("por_release", 200);

      // Table-driven runs.
      for (int i = 0; i < 8; i++) begin
         clear_stream();
         for (int k = 0; k < 4; k++) begin
            if (tab[i].da[k] != 8'hFF) dstream[int'(tab[i].da[k])][k] = 1'b1;
            if (tab[i].db[k] != 8'hFF) dstream[int'(tab[i].db[k])][k] = 1'b1;
         end
         run_scn($sformatf("vec%0d", i), tab[i].mask, (i % 3) == 0, (i % 2) == 0, done_at);
         check_int($sformatf("vec%0d_done_cycle", i), done_at, tab[i].exp_done);
      end

      // Mid-run reset with ap_start held high: abort, no retrigger, then a clean rerun.
      @(posedge ap_clk); #1;
      ap_start = 1'b0;
      @(posedge ap_clk); #1;
      ap_start = 1'b1;
      ch_mask  = 4'hF;
      for (int c = 0; c < 30; c++) @(posedge ap_clk);
      #1 ap_rst = 1'b1;
      @(negedge ap_clk);
      check("midrst_async", 30, {ch_rst_n, ch_start, ap_done, ap_idle}, OUT_RST);
      for (int c = 31; c <= 32; c++) begin
         @(posedge ap_clk);
         @(negedge ap_clk);
         check("midrst_hold", c, {ch_rst_n, ch_start, ap_done, ap_idle}, OUT_RST);
      end
      release_watch("midrst_no_retrigger", 120);
      ap_start = 1'b0;
      clear_stream();
      for (int k = 0; k < 4; k++) dstream[70][k] = 1'b1;
      run_scn("rerun_after_rst", 4'hF, 1'b0, 1'b0, done_at);
      check_int("rerun_done_cycle", done_at, 77);

      // Random runs: noise everywhere, plus a guaranteed done pulse/level per channel in RUN.
      for (int r = 0; r < 14; r++) begin
         logic [3:0] m;
         m = 4'($urandom_range(0, 15));
         clear_stream();
         for (int c = 0; c < LEN; c++) begin
            if (c <= ST) dstream[c] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            else         dstream[c] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         end
         for (int k = 0; k < 4; k++) begin
            int at;
            int len;
            at  = ST + 1 + $urandom_range(0, 40);
            len = $urandom_range(1, 4);
            for (int c = at; c < at + len; c++) dstream[c][k] = 1'b1;
         end
         run_scn($sformatf("rand%0d", r), m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), done_at);
         check_int($sformatf("rand%0d_done_cycle", r), done_at, cdone + 1 + OUT_PIPE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
